// File: rtl/tartaruga_pkg.sv
// Shared types for the tartaruga core: 32-bit bus word and dcache arbiter
// state encoding.
package tartaruga_pkg;

  typedef logic [31:0] bus32_t;

  localparam int unsigned DCACHE_ARB_STARVE_LIMIT_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_LD = 2'd1,
    BUSY_ST = 2'd2
  } dcache_arb_state_t;

endpackage

// File: rtl/dcache_port_arbiter.sv
// Arbitrates the mem-stage load port and the store-buffer drain onto the single
// dcache port. Optional perf counters are enabled by defining DCACHE_ARB_PERF_EN.
module dcache_port_arbiter
  import tartaruga_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = DCACHE_ARB_STARVE_LIMIT_DEFAULT
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   ld_valid_i,
  input  bus32_t ld_addr_i,
  output logic   ld_ready_o,
  output bus32_t ld_data_o,
  input  logic   st_valid_i,
  input  bus32_t st_addr_i,
  input  bus32_t st_data_i,
  output logic   st_ready_o,
  input  logic   sb_full_i,
  output logic   dc_valid_o,
  output logic   dc_we_o,
  output bus32_t dc_addr_o,
  output bus32_t dc_data_wr_o,
  input  logic   dc_ready_i,
  input  bus32_t dc_data_rd_i
`ifdef DCACHE_ARB_PERF_EN
  ,
  output bus32_t perf_ld_cnt_o,
  output bus32_t perf_st_cnt_o,
  output bus32_t perf_conflict_cnt_o
`endif
);

  localparam int unsigned CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  dcache_arb_state_t state_q;
  logic [CW-1:0]     starve_q;
  bus32_t            addr_q;
  bus32_t            data_q;

  logic   grant_ld;
  logic   grant_st;
  logic   starved;
  bus32_t out_addr;
  bus32_t out_data;

  assign starved = (starve_q == CW'(STARVE_LIMIT));

  // Reset gates the whole grant path so every output reads 0 while rst_i is high.
  always_comb begin
    grant_ld = 1'b0;
    grant_st = 1'b0;
    out_addr = '0;
    out_data = '0;
    if (!rst_i) begin
      unique case (state_q)
        IDLE: begin
          grant_st = st_valid_i && (!ld_valid_i || sb_full_i || starved);
          grant_ld = ld_valid_i && !grant_st;
          if (grant_st) begin
            out_addr = st_addr_i;
            out_data = st_data_i;
          end else if (grant_ld) begin
            out_addr = ld_addr_i;
          end
        end
        BUSY_LD: begin
          grant_ld = 1'b1;
          out_addr = addr_q;
        end
        BUSY_ST: begin
          grant_st = 1'b1;
          out_addr = addr_q;
          out_data = data_q;
        end
        default: ;
      endcase
    end
  end

  assign dc_valid_o   = grant_ld || grant_st;
  assign dc_we_o      = grant_st;
  assign dc_addr_o    = out_addr;
  assign dc_data_wr_o = out_data;
  assign ld_ready_o   = grant_ld && dc_ready_i;
  assign st_ready_o   = grant_st && dc_ready_i;
  assign ld_data_o    = ld_ready_o ? dc_data_rd_i : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      starve_q <= '0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (dc_valid_o && !dc_ready_i) begin
            state_q <= grant_st ? BUSY_ST : BUSY_LD;
            addr_q  <= out_addr;
            data_q  <= out_data;
          end
        end
        BUSY_LD, BUSY_ST: begin
          if (dc_ready_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      if (!st_valid_i || st_ready_o) begin
        starve_q <= '0;
      end else if (!starved) begin
        starve_q <= starve_q + 1'b1;
      end
    end
  end

`ifdef DCACHE_ARB_PERF_EN
  bus32_t perf_ld_q;
  bus32_t perf_st_q;
  bus32_t perf_conf_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_ld_q   <= '0;
      perf_st_q   <= '0;
      perf_conf_q <= '0;
    end else begin
      if (ld_ready_o) perf_ld_q <= perf_ld_q + 32'd1;
      if (st_ready_o) perf_st_q <= perf_st_q + 32'd1;
      if (state_q == IDLE && ld_valid_i && st_valid_i) perf_conf_q <= perf_conf_q + 32'd1;
    end
  end

  assign perf_ld_cnt_o       = perf_ld_q;
  assign perf_st_cnt_o       = perf_st_q;
  assign perf_conflict_cnt_o = perf_conf_q;
`endif

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed bench for dcache_port_arbiter: a cycle-by-cycle vector table plus
// hand sequences for starvation, reset mid-access and (if DCACHE_ARB_PERF_EN) perf counters.
module tb_dcache_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_valid, st_valid, sb_full, dc_ready;
  logic [31:0] ld_addr, st_addr, st_data, dc_rd;
  logic        ld_ready, st_ready, dc_valid, dc_we;
  logic [31:0] ld_data, dc_addr, dc_wr;
`ifdef DCACHE_ARB_PERF_EN
  logic [31:0] perf_ld, perf_st, perf_conf;
`endif

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  dcache_port_arbiter #(.STARVE_LIMIT(8)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .ld_valid_i   (ld_valid),
    .ld_addr_i    (ld_addr),
    .ld_ready_o   (ld_ready),
    .ld_data_o    (ld_data),
    .st_valid_i   (st_valid),
    .st_addr_i    (st_addr),
    .st_data_i    (st_data),
    .st_ready_o   (st_ready),
    .sb_full_i    (sb_full),
    .dc_valid_o   (dc_valid),
    .dc_we_o      (dc_we),
    .dc_addr_o    (dc_addr),
    .dc_data_wr_o (dc_wr),
    .dc_ready_i   (dc_ready),
    .dc_data_rd_i (dc_rd)
`ifdef DCACHE_ARB_PERF_EN
    ,
    .perf_ld_cnt_o       (perf_ld),
    .perf_st_cnt_o       (perf_st),
    .perf_conflict_cnt_o (perf_conf)
`endif
  );

  typedef struct {
    logic        rst;
    logic        ldv;
    logic [31:0] lda;
    logic        stv;
    logic [31:0] sta;
    logic [31:0] std;
    logic        sbf;
    logic        rdy;
    logic [31:0] rd;
    logic        e_dcv;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wr;
    logic        e_ldr;
    logic [31:0] e_ldd;
    logic        e_str;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic r, input logic lv, input logic [31:0] la,
                        input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                        input logic sf, input logic rdy, input logic [31:0] rd);
    rst = r; ld_valid = lv; ld_addr = la; st_valid = sv; st_addr = sa;
    st_data = sd; sb_full = sf; dc_ready = rdy; dc_rd = rd;
  endtask

  initial begin
    set_in(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, '0);

    //          rst  ldv lda          stv sta          std          sbf  rdy  rd            dcv we  addr         wr           ldr ldd          str
    tbl[0]  = '{1'b1,1'b1,32'h100,    1'b1,32'h200,    32'hDEAD,    1'b0,1'b1,32'hFFFFFFFF, 1'b0,1'b0,32'h0,      32'h0,       1'b0,32'h0,       1'b0};
    tbl[1]  = '{1'b0,1'b1,32'h100,    1'b0,32'h0,      32'h0,       1'b0,1'b1,32'hCAFE0001, 1'b1,1'b0,32'h100,    32'h0,       1'b1,32'hCAFE0001,1'b0};
    tbl[2]  = '{1'b0,1'b0,32'h0,      1'b0,32'h0,      32'h0,       1'b0,1'b1,32'h0,        1'b0,1'b0,32'h0,      32'h0,       1'b0,32'h0,       1'b0};
    tbl[3]  = '{1'b0,1'b0,32'h0,      1'b1,32'h200,    32'hDEAD,    1'b0,1'b0,32'h0,        1'b1,1'b1,32'h200,    32'hDEAD,    1'b0,32'h0,       1'b0};
    tbl[4]  = '{1'b0,1'b1,32'h300,    1'b1,32'h200,    32'hDEAD,    1'b0,1'b0,32'h0,        1'b1,1'b1,32'h200,    32'hDEAD,    1'b0,32'h0,       1'b0};
    tbl[5]  = '{1'b0,1'b1,32'h300,    1'b1,32'h200,    32'hDEAD,    1'b0,1'b0,32'h0,        1'b1,1'b1,32'h200,    32'hDEAD,    1'b0,32'h0,       1'b0};
    tbl[6]  = '{1'b0,1'b1,32'h300,    1'b1,32'h200,    32'hDEAD,    1'b0,1'b1,32'h55,       1'b1,1'b1,32'h200,    32'hDEAD,    1'b0,32'h0,       1'b1};
    tbl[7]  = '{1'b0,1'b1,32'h300,    1'b0,32'h0,      32'h0,       1'b0,1'b1,32'h1234,     1'b1,1'b0,32'h300,    32'h0,       1'b1,32'h1234,    1'b0};
    tbl[8]  = '{1'b0,1'b1,32'h400,    1'b1,32'h500,    32'hBEEF,    1'b1,1'b1,32'h0,        1'b1,1'b1,32'h500,    32'hBEEF,    1'b0,32'h0,       1'b1};
    tbl[9]  = '{1'b0,1'b1,32'h600,    1'b0,32'h0,      32'h0,       1'b0,1'b0,32'h0,        1'b1,1'b0,32'h600,    32'h0,       1'b0,32'h0,       1'b0};
    tbl[10] = '{1'b0,1'b0,32'h0,      1'b1,32'h700,    32'h11,      1'b1,1'b0,32'h0,        1'b1,1'b0,32'h600,    32'h0,       1'b0,32'h0,       1'b0};
    tbl[11] = '{1'b0,1'b0,32'h0,      1'b1,32'h700,    32'h11,      1'b1,1'b1,32'h77,       1'b1,1'b0,32'h600,    32'h0,       1'b1,32'h77,      1'b0};
    tbl[12] = '{1'b0,1'b0,32'h0,      1'b1,32'h700,    32'h11,      1'b0,1'b1,32'h0,        1'b1,1'b1,32'h700,    32'h11,      1'b0,32'h0,       1'b1};

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      set_in(tbl[i].rst, tbl[i].ldv, tbl[i].lda, tbl[i].stv, tbl[i].sta, tbl[i].std,
             tbl[i].sbf, tbl[i].rdy, tbl[i].rd);
      #1;
      chk($sformatf("v%0d dc_valid", i), {31'b0, dc_valid}, {31'b0, tbl[i].e_dcv});
      chk($sformatf("v%0d dc_we", i),    {31'b0, dc_we},    {31'b0, tbl[i].e_we});
      chk($sformatf("v%0d dc_addr", i),  dc_addr,           tbl[i].e_addr);
      chk($sformatf("v%0d dc_wr", i),    dc_wr,             tbl[i].e_wr);
      chk($sformatf("v%0d ld_ready", i), {31'b0, ld_ready}, {31'b0, tbl[i].e_ldr});
      chk($sformatf("v%0d ld_data", i),  ld_data,           tbl[i].e_ldd);
      chk($sformatf("v%0d st_ready", i), {31'b0, st_ready}, {31'b0, tbl[i].e_str});
    end

    // Store refused for 8 consecutive cycles, forced through on the 9th.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      set_in(1'b0, 1'b1, 32'h800, 1'b1, 32'h900, 32'hA5A5, 1'b0, 1'b1, 32'h42);
      #1;
      if (c == 8) begin
        chk("starve st_ready", {31'b0, st_ready}, 32'd1);
        chk("starve dc_we",    {31'b0, dc_we},    32'd1);
        chk("starve dc_addr",  dc_addr,           32'h900);
        chk("starve ld_ready", {31'b0, ld_ready}, 32'd0);
      end else begin
        chk($sformatf("starve c%0d ld_ready", c), {31'b0, ld_ready}, 32'd1);
        chk($sformatf("starve c%0d st_ready", c), {31'b0, st_ready}, 32'd0);
      end
    end

    // Reset while a load is locked on the port.
    @(negedge clk);
    set_in(1'b0, 1'b1, 32'hA00, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    #1;
    chk("busyld dc_valid", {31'b0, dc_valid}, 32'd1);
    chk("busyld dc_addr",  dc_addr,           32'hA00);
    @(negedge clk);
    set_in(1'b1, 1'b1, 32'hA00, 1'b0, '0, '0, 1'b0, 1'b1, 32'h99);
    #1;
    chk("inrst dc_valid", {31'b0, dc_valid}, 32'd0);
    chk("inrst ld_ready", {31'b0, ld_ready}, 32'd0);
    chk("inrst ld_data",  ld_data,           32'd0);
    @(negedge clk);
    set_in(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1, 32'h99);
    #1;
    chk("postrst dc_valid", {31'b0, dc_valid}, 32'd0);
    chk("postrst ld_ready", {31'b0, ld_ready}, 32'd0);
`ifdef DCACHE_ARB_PERF_EN
    chk("postrst perf_ld",   perf_ld,   32'd0);
    chk("postrst perf_st",   perf_st,   32'd0);
    chk("postrst perf_conf", perf_conf, 32'd0);

    // 2 conflict cycles (load wins), 3 lone loads, 3 lone stores.
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c < 2)      set_in(1'b0, 1'b1, 32'hB00, 1'b1, 32'hC00, 32'h1, 1'b0, 1'b1, 32'h5);
      else if (c < 5) set_in(1'b0, 1'b1, 32'hB00, 1'b0, '0, '0, 1'b0, 1'b1, 32'h5);
      else            set_in(1'b0, 1'b0, '0, 1'b1, 32'hC00, 32'h1, 1'b0, 1'b1, 32'h5);
    end
    @(negedge clk);
    set_in(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1, '0);
    #1;
    chk("perf_ld",   perf_ld,   32'd5);
    chk("perf_st",   perf_st,   32'd3);
    chk("perf_conf", perf_conf, 32'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dcache_port_arbiter.md
DCACHE_PORT_ARBITER -- requirements
Module: dcache_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 8: the number of consecutive cycles a store may be refused before it is forced onto the port.
REQ-002 SHALL have port clk_i  in  1  the single clock.
REQ-003 SHALL have port rst_i  in  1  reset, synchronous and active-high.
REQ-004 SHALL have ports ld_valid_i in 1, ld_addr_i in 32, ld_ready_o out 1, ld_data_o out 32: the load requester from the mem stage.
REQ-005 SHALL have ports st_valid_i in 1, st_addr_i in 32, st_data_i in 32, st_ready_o out 1: the store-buffer drain requester.
REQ-006 SHALL have port sb_full_i  in  1  store buffer full.
REQ-007 SHALL have ports dc_valid_o out 1, dc_we_o out 1, dc_addr_o out 32, dc_data_wr_o out 32, dc_ready_i in 1, dc_data_rd_i in 32: the single dcache port.

Function
REQ-008 SHALL implement an FSM with states IDLE, BUSY_LD and BUSY_ST.
REQ-009 In IDLE, SHALL grant combinationally.
- Load wins by default.
- Store wins when sb_full_i=1, or when the starve counter equals STARVE_LIMIT.
- Store wins when it is the only requester.
REQ-010 In IDLE with a grant, SHALL drive dc_valid_o=1, with dc_we_o/dc_addr_o/dc_data_wr_o taken from the winner (dc_we_o=1 only for a store).
REQ-011 In IDLE, when the grant and dc_ready_i=1 occur in the same cycle, SHALL complete the access that cycle with zero added latency and stay in IDLE.
REQ-012 In IDLE, when the grant occurs with dc_ready_i=0, SHALL register the winner's payload and move to BUSY_LD or BUSY_ST.
REQ-013 In BUSY_x, SHALL hold dc_valid_o=1 with the registered payload, ignoring all new requests and sb_full_i.
REQ-014 SHALL return from BUSY_x to IDLE on the first cycle with dc_ready_i=1.
REQ-015 SHALL assert ld_ready_o only in the completion cycle of a load, with ld_data_o=dc_data_rd_i; otherwise ld_data_o=0.
REQ-016 SHALL assert st_ready_o only in the completion cycle of a store.
REQ-017 If a locked requester drops its valid, SHALL still complete the access and pulse ready; the requester discards the result.
REQ-018 Starve counter: SHALL increment each cycle that st_valid_i=1 and the store does not complete, saturating at STARVE_LIMIT.
REQ-019 Starve counter: SHALL clear on store completion or when st_valid_i=0.
REQ-020 SHALL drive dc_valid_o=0 and all dc_* data outputs to 0 when there is no grant.
REQ-021 Address and data SHALL pass through unmodified at 32 bits; no address arithmetic.
REQ-022 SHALL NOT check ordering or forwarding; load-after-store bypass is owned by the store buffer.

Reset
REQ-023 rst_i=1 SHALL force, on the next edge: state to IDLE, starve counter to 0, payload registers to 0, and perf counters to 0.
REQ-024 Reset mid-operation SHALL abandon the locked access, with no ready pulse emitted.
REQ-025 While rst_i=1, SHALL hold all outputs at 0.

Configuration
REQ-026 With DCACHE_ARB_PERF_EN defined, SHALL add 32-bit outputs perf_ld_cnt_o, perf_st_cnt_o and perf_conflict_cnt_o.
- perf_ld_cnt_o counts completed loads.
- perf_st_cnt_o counts completed stores.
- perf_conflict_cnt_o counts IDLE cycles with ld_valid_i and st_valid_i both 1.
- All three wrap at 2^32.
REQ-027 Without DCACHE_ARB_PERF_EN, those ports and registers SHALL be absent; all other behaviour is identical.

Structure
REQ-028 SHALL define the FSM state enum dcache_arb_state_t and DCACHE_ARB_STARVE_LIMIT_DEFAULT in tartaruga_pkg, using the existing bus32_t for addresses and data.
REQ-029 SHALL be a single module with no sub-module.

Verification
REQ-030 Load only, ld_addr_i=0x100, dc_ready_i=1 same cycle -> dc_valid_o=1, dc_we_o=0, ld_ready_o=1, ld_data_o=dc_data_rd_i, state stays IDLE.
REQ-031 Load and store together, sb_full_i=0, dc_ready_i=1 -> load granted; after 8 consecutive refused store cycles, 9th cycle grants store, st_ready_o=1, dc_addr_o=st_addr_i.
REQ-032 Store 0x200/0xDEAD with dc_ready_i=0 for 3 cycles -> BUSY_ST; dc_addr_o=0x200 and dc_data_wr_o=0xDEAD held while a load arrives; st_ready_o on cycle 4; load granted cycle 5.
REQ-033 Load and store together with sb_full_i=1 -> store granted first regardless of the starve counter.
REQ-034 rst_i=1 during BUSY_LD -> next cycle IDLE, dc_valid_o=0, no ld_ready_o pulse; a perf build reads all counters 0.
REQ-035 Perf build, 5 loads and 3 stores with 2 conflict cycles -> perf_ld_cnt_o=5, perf_st_cnt_o=3, perf_conflict_cnt_o=2.
